// File: rtl/parking_gate_controller.sv
// parking_gate_controller
//   Sequences the car-park entry and exit barriers. NUM_ENTRY entry lanes are
//   round-robin arbitrated onto one shared entry path; one exit lane is served
//   by its own FSM. Emits registered car_entered / car_exited pulses (never
//   coincident) for the occupancy counter and gates entry grants on the
//   counter's space flags.
//   Optional feature macro: PARK_UNI_PRIORITY_EN (uni-permit lanes win
//   arbitration over non-uni lanes; round-robin within each class).
module parking_gate_controller #(
  parameter int NUM_ENTRY     = 2,
  parameter int OPEN_TIMEOUT  = 1000,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_ENTRY-1:0] ent_req,
  input  logic [NUM_ENTRY-1:0] ent_is_uni,
  input  logic [NUM_ENTRY-1:0] ent_pass,
  input  logic                 ext_req,
  input  logic                 ext_is_uni,
  input  logic                 ext_pass,
  input  logic                 uni_is_vacated_space,
  input  logic                 is_vacated_space,
  output logic [NUM_ENTRY-1:0] ent_gate_open,
  output logic [NUM_ENTRY-1:0] ent_reject,
  output logic                 ext_gate_open,
  output logic                 car_entered,
  output logic                 is_uni_car_entered,
  output logic                 car_exited,
  output logic                 is_uni_car_exited,
  output logic                 busy
);

  localparam int unsigned N    = NUM_ENTRY;
  localparam int          LW   = (NUM_ENTRY > 1) ? $clog2(NUM_ENTRY) : 1;
  localparam int          TMAX = (OPEN_TIMEOUT > SETTLE_CYCLES) ? OPEN_TIMEOUT : SETTLE_CYCLES;
  localparam int          TW   = $clog2(TMAX + 1);

  localparam logic [TW-1:0] OPEN_LAST   = TW'(OPEN_TIMEOUT - 1);
  localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYCLES - 1);
  localparam logic [LW-1:0] LAST_LANE   = LW'(NUM_ENTRY - 1);

  typedef enum logic [1:0] {E_IDLE, E_OPEN, E_CLOSE} ent_state_e;
  typedef enum logic [1:0] {X_IDLE, X_OPEN, X_CLOSE} ext_state_e;

  ent_state_e           e_state_q, e_state_d;
  logic [LW-1:0]        e_lane_q, e_lane_d;
  logic                 e_uni_q, e_uni_d;
  logic [TW-1:0]        e_tmr_q, e_tmr_d;
  logic [LW-1:0]        ptr_q, ptr_d;

  ext_state_e           x_state_q, x_state_d;
  logic                 x_uni_q, x_uni_d;
  logic [TW-1:0]        x_tmr_q, x_tmr_d;
  logic                 pend_q, pend_d;

  logic [NUM_ENTRY-1:0] gate_q, gate_d;
  logic [NUM_ENTRY-1:0] reject_q, reject_d;
  logic                 xgate_q, xgate_d;
  logic                 entered_q, entered_d;
  logic                 entered_uni_q, entered_uni_d;
  logic                 exited_q, exited_d;
  logic                 exited_uni_q, exited_uni_d;
  logic                 busy_q, busy_d;

  logic [NUM_ENTRY-1:0] cand;
  logic                 win_found;
  logic [LW-1:0]        win_lane;
  logic                 win_uni;
  logic                 win_flag;

  // Round-robin arbiter: first candidate lane at or above the pointer, with wrap
  always_comb begin
    logic [LW-1:0] idx;
    idx       = '0;
    win_found = 1'b0;
    win_lane  = '0;
`ifdef PARK_UNI_PRIORITY_EN
    cand = (|(ent_req & ent_is_uni)) ? (ent_req & ent_is_uni) : ent_req;
`else
    cand = ent_req;
`endif
    for (int unsigned i = 0; i < N; i++) begin
      idx = LW'((32'(ptr_q) + i) % N);
      if (!win_found && cand[idx]) begin
        win_found = 1'b1;
        win_lane  = idx;
      end
    end
    win_uni  = ent_is_uni[win_lane];
    win_flag = win_uni ? uni_is_vacated_space : is_vacated_space;
  end

  // Entry FSM next-state and entry-side registered outputs
  always_comb begin
    e_state_d     = e_state_q;
    e_lane_d      = e_lane_q;
    e_uni_d       = e_uni_q;
    e_tmr_d       = e_tmr_q;
    ptr_d         = ptr_q;
    reject_d      = '0;
    entered_d     = 1'b0;
    entered_uni_d = 1'b0;
    case (e_state_q)
      E_IDLE: begin
        if (win_found) begin
          ptr_d = (win_lane == LAST_LANE) ? '0 : win_lane + LW'(1);
          if (win_flag) begin
            e_state_d = E_OPEN;
            e_lane_d  = win_lane;
            e_uni_d   = win_uni;
            e_tmr_d   = '0;
          end else begin
            reject_d[win_lane] = 1'b1;
          end
        end
      end
      E_OPEN: begin
        if (ent_pass[e_lane_q]) begin
          entered_d     = 1'b1;
          entered_uni_d = e_uni_q;
          e_state_d     = E_CLOSE;
          e_tmr_d       = '0;
        end else if (e_tmr_q == OPEN_LAST) begin
          e_state_d = E_CLOSE;
          e_tmr_d   = '0;
        end else begin
          e_tmr_d = e_tmr_q + TW'(1);
        end
      end
      E_CLOSE: begin
        if (e_tmr_q == SETTLE_LAST) begin
          e_state_d = E_IDLE;
          e_tmr_d   = '0;
        end else begin
          e_tmr_d = e_tmr_q + TW'(1);
        end
      end
      default: e_state_d = E_IDLE;
    endcase
    gate_d = '0;
    if (e_state_d == E_OPEN) gate_d[e_lane_d] = 1'b1;
  end

  // Exit FSM next-state; an exit pass colliding with an entry pulse is deferred
  // one cycle via pend, and the close settle timer holds until it is issued
  always_comb begin
    x_state_d    = x_state_q;
    x_uni_d      = x_uni_q;
    x_tmr_d      = x_tmr_q;
    pend_d       = pend_q;
    exited_d     = 1'b0;
    exited_uni_d = 1'b0;
    case (x_state_q)
      X_IDLE: begin
        if (ext_req) begin
          x_state_d = X_OPEN;
          x_uni_d   = ext_is_uni;
          x_tmr_d   = '0;
        end
      end
      X_OPEN: begin
        if (ext_pass) begin
          x_state_d = X_CLOSE;
          x_tmr_d   = '0;
          if (entered_d) begin
            pend_d = 1'b1;
          end else begin
            exited_d     = 1'b1;
            exited_uni_d = x_uni_q;
          end
        end else if (x_tmr_q == OPEN_LAST) begin
          x_state_d = X_CLOSE;
          x_tmr_d   = '0;
        end else begin
          x_tmr_d = x_tmr_q + TW'(1);
        end
      end
      X_CLOSE: begin
        if (pend_q) begin
          exited_d     = 1'b1;
          exited_uni_d = x_uni_q;
          pend_d       = 1'b0;
        end else if (x_tmr_q == SETTLE_LAST) begin
          x_state_d = X_IDLE;
          x_tmr_d   = '0;
        end else begin
          x_tmr_d = x_tmr_q + TW'(1);
        end
      end
      default: x_state_d = X_IDLE;
    endcase
    xgate_d = (x_state_d == X_OPEN);
    busy_d  = (e_state_d != E_IDLE) || (x_state_d != X_IDLE) || pend_d;
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_state_q     <= E_IDLE;
      e_lane_q      <= '0;
      e_uni_q       <= 1'b0;
      e_tmr_q       <= '0;
      ptr_q         <= '0;
      x_state_q     <= X_IDLE;
      x_uni_q       <= 1'b0;
      x_tmr_q       <= '0;
      pend_q        <= 1'b0;
      gate_q        <= '0;
      reject_q      <= '0;
      xgate_q       <= 1'b0;
      entered_q     <= 1'b0;
      entered_uni_q <= 1'b0;
      exited_q      <= 1'b0;
      exited_uni_q  <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      e_state_q     <= e_state_d;
      e_lane_q      <= e_lane_d;
      e_uni_q       <= e_uni_d;
      e_tmr_q       <= e_tmr_d;
      ptr_q         <= ptr_d;
      x_state_q     <= x_state_d;
      x_uni_q       <= x_uni_d;
      x_tmr_q       <= x_tmr_d;
      pend_q        <= pend_d;
      gate_q        <= gate_d;
      reject_q      <= reject_d;
      xgate_q       <= xgate_d;
      entered_q     <= entered_d;
      entered_uni_q <= entered_uni_d;
      exited_q      <= exited_d;
      exited_uni_q  <= exited_uni_d;
      busy_q        <= busy_d;
    end
  end

  assign ent_gate_open      = gate_q;
  assign ent_reject         = reject_q;
  assign ext_gate_open      = xgate_q;
  assign car_entered        = entered_q;
  assign is_uni_car_entered = entered_uni_q;
  assign car_exited         = exited_q;
  assign is_uni_car_exited  = exited_uni_q;
  assign busy               = busy_q;

endmodule

// File: tb/tb_parking_gate_controller.sv
// Self-checking bench for parking_gate_controller: directed scenarios followed
// by random traffic, all compared cycle by cycle against a transaction-level
// model of the gate rules.
module tb_parking_gate_controller;

  localparam int NE = 2;
  localparam int TO = 20;
  localparam int SC = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NE-1:0] ent_req = '0, ent_is_uni = '0, ent_pass = '0;
  logic          ext_req = 1'b0, ext_is_uni = 1'b0, ext_pass = 1'b0;
  logic          uni_vac = 1'b1, gen_vac = 1'b1;
  logic [NE-1:0] ent_gate_open, ent_reject;
  logic          ext_gate_open, car_entered, is_uni_car_entered;
  logic          car_exited, is_uni_car_exited, busy;

  parking_gate_controller #(
    .NUM_ENTRY    (NE),
    .OPEN_TIMEOUT (TO),
    .SETTLE_CYCLES(SC)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .ent_req             (ent_req),
    .ent_is_uni          (ent_is_uni),
    .ent_pass            (ent_pass),
    .ext_req             (ext_req),
    .ext_is_uni          (ext_is_uni),
    .ext_pass            (ext_pass),
    .uni_is_vacated_space(uni_vac),
    .is_vacated_space    (gen_vac),
    .ent_gate_open       (ent_gate_open),
    .ent_reject          (ent_reject),
    .ext_gate_open       (ext_gate_open),
    .car_entered         (car_entered),
    .is_uni_car_entered  (is_uni_car_entered),
    .car_exited          (car_exited),
    .is_uni_car_exited   (is_uni_car_exited),
    .busy                (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: gate occupancy and countdowns, not state encodings
  int m_ptr, m_el, m_eage, m_eset, m_xage, m_xset;
  bit m_eo, m_eu, m_xo, m_xu, m_pend;
  logic [NE-1:0] e_gate, e_rej;
  logic e_xgate, e_ce, e_ceu, e_cx, e_cxu, e_busy;

  // Observation bookkeeping for directed checks
  int cyc = 0;
  int n_ce = 0, n_rej = 0, ce_cyc = -1, cx_cyc = -1;
  logic [NE-1:0] prev_gate = '0;
  int grants[$];

  function automatic void model_reset();
    m_ptr = 0; m_el = 0; m_eage = 0; m_eset = 0; m_xage = 0; m_xset = 0;
    m_eo = 0; m_eu = 0; m_xo = 0; m_xu = 0; m_pend = 0;
    e_gate = '0; e_rej = '0; e_xgate = 0; e_ce = 0; e_ceu = 0;
    e_cx = 0; e_cxu = 0; e_busy = 0;
  endfunction

  function automatic void model_step();
    int pick;
    bit flag;
    e_gate = '0; e_rej = '0; e_ce = 0; e_ceu = 0; e_cx = 0; e_cxu = 0;
    if (reset) begin
      model_reset();
      return;
    end
    // entry path
    if (m_eset > 0) begin
      m_eset--;
    end else if (m_eo) begin
      if (ent_pass[m_el]) begin
        e_ce = 1; e_ceu = m_eu; m_eo = 0; m_eset = SC;
      end else if (m_eage == TO - 1) begin
        m_eo = 0; m_eset = SC;
      end else begin
        m_eage++;
      end
    end else begin
      pick = -1;
`ifdef PARK_UNI_PRIORITY_EN
      for (int k = 0; k < NE; k++) begin
        int l;
        l = (m_ptr + k) % NE;
        if (pick < 0 && ent_req[l] && ent_is_uni[l]) pick = l;
      end
`endif
      for (int k = 0; k < NE; k++) begin
        int l;
        l = (m_ptr + k) % NE;
        if (pick < 0 && ent_req[l]) pick = l;
      end
      if (pick >= 0) begin
        m_ptr = (pick + 1) % NE;
        flag = ent_is_uni[pick] ? uni_vac : gen_vac;
        if (flag) begin
          m_eo = 1; m_el = pick; m_eu = ent_is_uni[pick]; m_eage = 0;
        end else begin
          e_rej[pick] = 1'b1;
        end
      end
    end
    if (m_eo) e_gate[m_el] = 1'b1;
    // exit path; a pass coinciding with an entry pulse is deferred by a cycle
    if (m_pend) begin
      e_cx = 1; e_cxu = m_xu; m_pend = 0;
    end else if (m_xset > 0) begin
      m_xset--;
    end else if (m_xo) begin
      if (ext_pass) begin
        m_xo = 0; m_xset = SC;
        if (e_ce) m_pend = 1;
        else begin e_cx = 1; e_cxu = m_xu; end
      end else if (m_xage == TO - 1) begin
        m_xo = 0; m_xset = SC;
      end else begin
        m_xage++;
      end
    end else if (ext_req) begin
      m_xo = 1; m_xu = ext_is_uni; m_xage = 0;
    end
    e_xgate = m_xo;
    e_busy  = m_eo || (m_eset > 0) || m_xo || (m_xset > 0) || m_pend;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_outputs();
    chk("ent_gate_open", 32'(ent_gate_open), 32'(e_gate));
    chk("ent_reject", 32'(ent_reject), 32'(e_rej));
    chk("ext_gate_open", 32'(ext_gate_open), 32'(e_xgate));
    chk("car_entered", 32'(car_entered), 32'(e_ce));
    chk("is_uni_car_entered", 32'(is_uni_car_entered), 32'(e_ceu));
    chk("car_exited", 32'(car_exited), 32'(e_cx));
    chk("is_uni_car_exited", 32'(is_uni_car_exited), 32'(e_cxu));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("pulse_exclusive", 32'(car_entered & car_exited), 32'd0);
    if (car_entered === 1'b1) begin n_ce++; ce_cyc = cyc; end
    if (car_exited === 1'b1) cx_cyc = cyc;
    if (ent_reject !== '0) n_rej++;
    if (prev_gate == '0 && ent_gate_open != '0) grants.push_back(ent_gate_open[1] ? 1 : 0);
    prev_gate = ent_gate_open;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    check_outputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  initial begin
    model_reset();
    // reset state
    reset = 1'b1;
    run(2);
    reset = 1'b0;

    // single uni car on lane 0, pass five cycles after grant
    n_ce = 0;
    ent_req = 2'b01; ent_is_uni = 2'b01;
    cycle();
    ent_req = 2'b00;
    run(4);
    ent_pass = 2'b01;
    cycle();
    ent_pass = 2'b00;
    run(SC + 3);
    chk("t1_entries", 32'(n_ce), 32'd1);

    // both lanes requesting, prompt passes: alternating grants
    do_reset();
    n_ce = 0; grants.delete();
    ent_req = 2'b11; ent_is_uni = 2'b00;
    for (int i = 0; i < 24; i++) begin
      ent_pass = '0;
      if (m_eo && m_eage >= 1) ent_pass[m_el] = 1'b1;
      cycle();
    end
    ent_req = '0; ent_pass = '0;
    run(SC + 4);
    chk("t2_grant_count", 32'(grants.size() >= 3), 32'd1);
    if (grants.size() >= 3) begin
      chk("t2_grant0", 32'(grants[0]), 32'd0);
      chk("t2_grant1", 32'(grants[1]), 32'd1);
      chk("t2_grant2", 32'(grants[2]), 32'd0);
    end
    chk("t2_entries_per_grant", 32'(n_ce), 32'(grants.size()));

    // general section full: non-uni request on lane 1 is refused
    n_ce = 0; n_rej = 0;
    gen_vac = 1'b0;
    ent_req = 2'b10; ent_is_uni = 2'b00;
    cycle();
    ent_req = '0;
    run(4);
    chk("t3_rejects", 32'(n_rej), 32'd1);
    chk("t3_entries", 32'(n_ce), 32'd0);
    gen_vac = 1'b1;

    // grant without a pass: timeout closes the gate, nothing counted
    n_ce = 0;
    ent_req = 2'b01;
    cycle();
    ent_req = '0;
    run(TO + SC + 4);
    chk("t4_entries", 32'(n_ce), 32'd0);
    chk("t4_idle_busy", 32'(busy), 32'd0);

    // simultaneous entry and exit pass: entry pulse first, exit one cycle later
    ce_cyc = -1; cx_cyc = -1;
    ent_req = 2'b01; ent_is_uni = 2'b00; ext_req = 1'b1; ext_is_uni = 1'b1;
    cycle();
    ent_req = '0; ext_req = 1'b0;
    run(3);
    ent_pass = 2'b01; ext_pass = 1'b1;
    cycle();
    ent_pass = '0; ext_pass = 1'b0;
    run(SC + 5);
    chk("t5_entry_seen", 32'(ce_cyc > 0), 32'd1);
    chk("t5_exit_after_entry", 32'(cx_cyc - ce_cyc), 32'd1);

    // reset while lane 1 gate is open, then lane 0 arbitrated first
    ent_req = 2'b10; ent_is_uni = 2'b00;
    run(2);
    chk("t6_lane1_open", 32'(ent_gate_open), 32'h2);
    reset = 1'b1;
    #1;
    chk("t6_rst_gate", 32'(ent_gate_open), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_pulses", 32'({car_entered, car_exited, ent_reject, ext_gate_open}), 32'd0);
    model_reset();
    run(1);
    reset = 1'b0;
    ent_req = 2'b11;
    cycle();
    chk("t6_lane0_first", 32'(ent_gate_open), 32'h1);
    ent_req = '0;
    run(TO + SC + 2);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      ent_req    = NE'($urandom_range(0, 3));
      ent_is_uni = NE'($urandom_range(0, 3));
      ent_pass   = '0;
      for (int l = 0; l < NE; l++) ent_pass[l] = ($urandom_range(0, 3) == 0);
      ext_req    = ($urandom_range(0, 2) == 0);
      ext_is_uni = $urandom_range(0, 1) == 1;
      ext_pass   = ($urandom_range(0, 3) == 0);
      uni_vac    = ($urandom_range(0, 3) != 0);
      gen_vac    = ($urandom_range(0, 3) != 0);
      reset      = ($urandom_range(0, 499) == 0);
      cycle();
    end
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
